// File: rtl/bg_index_fetch_pkg.sv
// Shared constants, types and the image-content function for the background index fetch.
package bg_pkg;

  localparam int SCR_W       = 640;
  localparam int SCR_H       = 480;
  localparam int IMG_W       = 320;
  localparam int IMG_H       = 240;
  localparam int SCALE_SH    = 1;
  localparam int IDX_W       = 5;
  localparam int ADDR_W      = 17;
  localparam int BG_PIPE_LAT = 3;

  typedef logic [IDX_W-1:0]  bg_idx_t;
  typedef logic [ADDR_W-1:0] bg_addr_t;
  typedef logic [9:0]        bg_coord_t;
  typedef logic [8:0]        bg_scroll_t;

  typedef struct packed {
    logic de;
    logic hs;
    logic vs;
  } bg_timing_t;

  // Blanking state of the timing bits: sync lines are active-low, so idle is high.
  localparam bg_timing_t BG_TIMING_IDLE = '{de: 1'b0, hs: 1'b1, vs: 1'b1};

  // Image content: every texel index is a fold of its address bits, so any
  // texel is reproducible from its address without an external image file.
  function automatic bg_idx_t bg_rom_word(input bg_addr_t a);
    return a[4:0] ^ a[9:5] ^ a[14:10] ^ {3'b000, a[16:15]} ^ 5'd7;
  endfunction

  function automatic bg_scroll_t bg_wrap_scroll(input bg_scroll_t s);
    bg_scroll_t r;
    if (s >= 9'(IMG_W)) begin
      r = s - 9'(IMG_W);
    end else begin
      r = s;
    end
    return r;
  endfunction

endpackage

// File: rtl/bg_index_fetch_if.sv
// Pixel stream bundle between the VGA controller side (master) and the index fetch (slave).
interface bg_index_fetch_if;
  import bg_pkg::*;

  bg_coord_t  draw_x;
  bg_coord_t  draw_y;
  logic       de_in;
  logic       hs_in;
  logic       vs_in;
  bg_scroll_t scroll_x;
  bg_idx_t    index;
  logic       de_out;
  logic       hs_out;
  logic       vs_out;

  modport master (
    output draw_x, draw_y, de_in, hs_in, vs_in, scroll_x,
    input  index, de_out, hs_out, vs_out
  );

  modport slave (
    input  draw_x, draw_y, de_in, hs_in, vs_in, scroll_x,
    output index, de_out, hs_out, vs_out
  );

endinterface

// File: rtl/bg_index_fetch_rom.sv
// Synchronous single-port image ROM; output register reads 0 when the enable is low.
module bg_rom
  import bg_pkg::*;
(
  input  logic     clk,
  input  logic     reset_n,
  input  logic     en,
  input  bg_addr_t addr,
  output bg_idx_t  q
);

  bg_idx_t q_d;
  bg_idx_t q_q;

  // Next read word; gated so blanking and out-of-range pixels read black.
  always_comb begin
    q_d = {IDX_W{1'b0}};
    if (en) begin
      q_d = bg_rom_word(addr);
    end else begin
      q_d = {IDX_W{1'b0}};
    end
  end

  // Read register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q_q <= {IDX_W{1'b0}};
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/bg_index_fetch.sv
// Maps VGA pixel coordinates to 2x-upscaled image texels and fetches the palette index, 3-cycle latency.
// Optional horizontal scroll with wrap is enabled by defining BG_SCROLL_EN.
module bg_index_fetch
  import bg_pkg::*;
(
  input  logic            clk,
  input  logic            reset_n,
  bg_index_fetch_if.slave bus
);

  bg_coord_t  x0_d, x0_q;
  bg_coord_t  y0_d, y0_q;
  bg_timing_t t0_d, t0_q;
  bg_timing_t t1_d, t1_q;
  bg_timing_t t2_d, t2_q;
  bg_addr_t   addr_d, addr_q;
  logic       valid1_d, valid1_q;
  logic [9:0] x_half_s;
  logic [9:0] tx_s;
  logic [9:0] ty_s;
  logic       in_range_s;
  bg_idx_t    rom_q_s;

  // Stage 0 capture of the incoming pixel.
  always_comb begin
    x0_d = bus.draw_x;
    y0_d = bus.draw_y;
    t0_d = '{de: bus.de_in, hs: bus.hs_in, vs: bus.vs_in};
  end

  assign x_half_s = x0_q >> SCALE_SH;

`ifdef BG_SCROLL_EN
  bg_scroll_t scroll_d, scroll_q;
  logic [9:0] tx_sum_s;

  // Scroll only changes on a falling registered vsync so a frame never tears.
  always_comb begin
    scroll_d = scroll_q;
    if (t1_q.vs && !t0_q.vs) begin
      scroll_d = bg_wrap_scroll(bus.scroll_x);
    end else begin
      scroll_d = scroll_q;
    end
  end

  // Scroll register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      scroll_q <= 9'd0;
    end else begin
      scroll_q <= scroll_d;
    end
  end

  // Scrolled texel column, wrapped once since both terms are below the image width.
  always_comb begin
    tx_sum_s = x_half_s + {1'b0, scroll_q};
    if (tx_sum_s >= 10'(IMG_W)) begin
      tx_s = tx_sum_s - 10'(IMG_W);
    end else begin
      tx_s = tx_sum_s;
    end
  end
`else
  // Unscrolled texel column.
  always_comb begin
    tx_s = x_half_s;
  end
`endif

  // Stage 1 address: shift-add for the 320-wide image, constant multiply otherwise.
  always_comb begin
    ty_s       = y0_q >> SCALE_SH;
    in_range_s = (x0_q < 10'(SCR_W)) && (y0_q < 10'(SCR_H));
    addr_d     = {ADDR_W{1'b0}};
    if (in_range_s) begin
      if (IMG_W == 320) begin
        addr_d = (bg_addr_t'(ty_s) << 8) + (bg_addr_t'(ty_s) << 6) + bg_addr_t'(tx_s);
      end else begin
        addr_d = bg_addr_t'(ty_s) * ADDR_W'(IMG_W) + bg_addr_t'(tx_s);
      end
    end else begin
      addr_d = {ADDR_W{1'b0}};
    end
    valid1_d = t0_q.de & in_range_s;
    t1_d     = t0_q;
    t2_d     = t1_q;
  end

  // Pipeline registers for coordinates, address and timing bits.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x0_q     <= 10'd0;
      y0_q     <= 10'd0;
      t0_q     <= BG_TIMING_IDLE;
      t1_q     <= BG_TIMING_IDLE;
      t2_q     <= BG_TIMING_IDLE;
      addr_q   <= {ADDR_W{1'b0}};
      valid1_q <= 1'b0;
    end else begin
      x0_q     <= x0_d;
      y0_q     <= y0_d;
      t0_q     <= t0_d;
      t1_q     <= t1_d;
      t2_q     <= t2_d;
      addr_q   <= addr_d;
      valid1_q <= valid1_d;
    end
  end

  bg_rom u_rom (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (valid1_q),
    .addr    (addr_q),
    .q       (rom_q_s)
  );

  assign bus.index  = rom_q_s;
  assign bus.de_out = t2_q.de;
  assign bus.hs_out = t2_q.hs;
  assign bus.vs_out = t2_q.vs;

endmodule

// File: tb/tb_bg_index_fetch.sv
// Directed self-checking bench for bg_index_fetch (builds with or without BG_SCROLL_EN).
module tb_bg_index_fetch;
  import bg_pkg::*;

  logic clk;
  logic reset_n;
  int   n_checks;
  int   n_pass;

  bg_index_fetch_if bus ();

  bg_index_fetch dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_in(input int x, input int y, input logic de, input logic hs, input logic vs);
    bus.draw_x = 10'(x);
    bus.draw_y = 10'(y);
    bus.de_in  = de;
    bus.hs_in  = hs;
    bus.vs_in  = vs;
  endtask

  // Drive one pixel for one cycle, then idle; return index seen 3 cycles later.
  task automatic pix_index(input int x, input int y, input logic de, output logic [4:0] idx);
    @(negedge clk);
    set_in(x, y, de, 1'b1, 1'b1);
    @(negedge clk);
    set_in(0, 0, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    @(negedge clk);
    idx = bus.index;
  endtask

  task automatic vs_fall(input int sx);
    @(negedge clk);
    bus.scroll_x = 9'(sx);
    set_in(0, 0, 1'b0, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    set_in(0, 0, 1'b0, 1'b1, 1'b1);
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    logic [4:0] idx;
    reset_n = 1'b0;
    bus.scroll_x = 9'd0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      set_in($urandom_range(0, 1023), $urandom_range(0, 1023), 1'($urandom), 1'($urandom), 1'($urandom));
    end
    #1;
    n_checks += 4;
    if (bus.index !== 5'd0) $display("FAIL reset_index actual=%0d expected=0", bus.index); else n_pass++;
    if (bus.de_out !== 1'b0) $display("FAIL reset_de actual=%b expected=0", bus.de_out); else n_pass++;
    if (bus.hs_out !== 1'b1) $display("FAIL reset_hs actual=%b expected=1", bus.hs_out); else n_pass++;
    if (bus.vs_out !== 1'b1) $display("FAIL reset_vs actual=%b expected=1", bus.vs_out); else n_pass++;
    @(negedge clk);
    set_in(0, 0, 1'b0, 1'b1, 1'b1);
    reset_n = 1'b1;
    @(negedge clk);
    set_in(0, 0, 1'b1, 1'b1, 1'b1);
    @(negedge clk);
    set_in(0, 0, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    n_checks++;
    if (bus.index !== 5'd0) $display("FAIL first_early actual=%0d expected=0", bus.index); else n_pass++;
    @(negedge clk);
    n_checks++;
    if (bus.index !== 5'd7) $display("FAIL first_rom0 actual=%0d expected=7", bus.index); else n_pass++;
    pix_index(0, 0, 1'b1, idx);
  endtask

  task automatic test_mapping();
    int         xs [6] = '{2, 3, 5, 100, 639, 0};
    int         ys [6] = '{0, 1, 3, 200, 479, 479};
    logic [4:0] exp_idx [6] = '{5'd6, 5'd6, 5'd15, 5'd3, 5'd15, 5'd25};
    logic [4:0] idx;
    for (int i = 0; i < 6; i++) begin
      pix_index(xs[i], ys[i], 1'b1, idx);
      n_checks++;
      if (idx !== exp_idx[i])
        $display("FAIL map_%0d_%0d actual=%0d expected=%0d", xs[i], ys[i], idx, exp_idx[i]);
      else n_pass++;
    end
  endtask

  task automatic test_blanking();
    int   xs [3] = '{700, 0, 640};
    int   ys [3] = '{0, 480, 0};
    logic des [3] = '{1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      set_in(xs[i], ys[i], des[i], 1'b1, 1'b1);
      @(negedge clk);
      set_in(0, 0, 1'b0, 1'b1, 1'b1);
      @(negedge clk);
      n_checks++;
      if (dut.addr_q !== 17'd0)
        $display("FAIL blank_addr_%0d actual=%0d expected=0", i, dut.addr_q);
      else n_pass++;
      @(negedge clk);
      n_checks += 2;
      if (bus.index !== 5'd0) $display("FAIL blank_index_%0d actual=%0d expected=0", i, bus.index); else n_pass++;
      if (bus.de_out !== des[i]) $display("FAIL blank_de_%0d actual=%b expected=%b", i, bus.de_out, des[i]); else n_pass++;
    end
  endtask

  task automatic test_timing();
    logic [39:0] de_h, hs_h, vs_h;
    logic [4:0]  exp_idx;
    bus.scroll_x = 9'd0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (i >= 3) begin
        exp_idx = de_h[i-3] ? 5'd7 : 5'd0;
        n_checks += 4;
        if (bus.de_out !== de_h[i-3]) $display("FAIL align_de_%0d actual=%b expected=%b", i, bus.de_out, de_h[i-3]); else n_pass++;
        if (bus.hs_out !== hs_h[i-3]) $display("FAIL align_hs_%0d actual=%b expected=%b", i, bus.hs_out, hs_h[i-3]); else n_pass++;
        if (bus.vs_out !== vs_h[i-3]) $display("FAIL align_vs_%0d actual=%b expected=%b", i, bus.vs_out, vs_h[i-3]); else n_pass++;
        if (bus.index !== exp_idx) $display("FAIL align_idx_%0d actual=%0d expected=%0d", i, bus.index, exp_idx); else n_pass++;
      end
      de_h[i] = 1'($urandom);
      hs_h[i] = 1'($urandom);
      vs_h[i] = 1'($urandom);
      set_in(0, 0, de_h[i], hs_h[i], vs_h[i]);
    end
    @(negedge clk);
    set_in(0, 0, 1'b0, 1'b1, 1'b1);
    repeat (3) @(negedge clk);
  endtask

  task automatic test_scroll();
    logic [4:0] idx;
    logic [4:0] exp_630;
    logic [4:0] exp_0;
`ifdef BG_SCROLL_EN
    exp_630 = 5'd2;
    exp_0   = 5'd2;
`else
    exp_630 = 5'd21;
    exp_0   = 5'd7;
`endif
    vs_fall(10);
    pix_index(630, 0, 1'b1, idx);
    n_checks++;
    if (idx !== exp_630) $display("FAIL scroll_wrap actual=%0d expected=%0d", idx, exp_630); else n_pass++;
    @(negedge clk);
    bus.scroll_x = 9'd100;
    pix_index(630, 0, 1'b1, idx);
    n_checks++;
    if (idx !== exp_630) $display("FAIL scroll_midframe actual=%0d expected=%0d", idx, exp_630); else n_pass++;
    vs_fall(330);
    pix_index(630, 0, 1'b1, idx);
    n_checks++;
    if (idx !== exp_630) $display("FAIL scroll_reduce actual=%0d expected=%0d", idx, exp_630); else n_pass++;
    vs_fall(5);
    pix_index(0, 0, 1'b1, idx);
    n_checks++;
    if (idx !== exp_0) $display("FAIL scroll_x0 actual=%0d expected=%0d", idx, exp_0); else n_pass++;
  endtask

  task automatic test_midframe_reset();
    logic [4:0] idx;
    @(negedge clk);
    bus.scroll_x = 9'd0;
    set_in(5, 3, 1'b1, 1'b0, 1'b0);
    repeat (6) @(negedge clk);
    reset_n = 1'b0;
    #1;
    n_checks += 4;
    if (bus.index !== 5'd0) $display("FAIL mid_rst_index actual=%0d expected=0", bus.index); else n_pass++;
    if (bus.de_out !== 1'b0) $display("FAIL mid_rst_de actual=%b expected=0", bus.de_out); else n_pass++;
    if (bus.hs_out !== 1'b1) $display("FAIL mid_rst_hs actual=%b expected=1", bus.hs_out); else n_pass++;
    if (bus.vs_out !== 1'b1) $display("FAIL mid_rst_vs actual=%b expected=1", bus.vs_out); else n_pass++;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if (bus.de_out !== 1'b0) $display("FAIL mid_early_de actual=%b expected=0", bus.de_out); else n_pass++;
    @(negedge clk);
    n_checks += 3;
    if (bus.index !== 5'd15) $display("FAIL mid_resume_index actual=%0d expected=15", bus.index); else n_pass++;
    if (bus.de_out !== 1'b1) $display("FAIL mid_resume_de actual=%b expected=1", bus.de_out); else n_pass++;
    if (bus.hs_out !== 1'b0) $display("FAIL mid_resume_hs actual=%b expected=0", bus.hs_out); else n_pass++;
    set_in(0, 0, 1'b0, 1'b1, 1'b1);
    repeat (3) @(negedge clk);
    pix_index(630, 0, 1'b1, idx);
    n_checks++;
    if (idx !== 5'd21) $display("FAIL mid_scroll_cleared actual=%0d expected=21", idx); else n_pass++;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    reset_n  = 1'b0;
    set_in(0, 0, 1'b0, 1'b1, 1'b1);
    bus.scroll_x = 9'd0;
    test_reset();
    test_mapping();
    test_blanking();
    test_timing();
    test_scroll();
    test_midframe_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
